// File: rtl/div_issue_ctrl.sv
// Issue controller for the M-extension divider: launches divisions, holds operands,
// returns quotient/remainder over valid/ready and serves repeat operands from a one-entry cache.
module div_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        div_en,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_is_signed,
  input  logic        div_ready,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_div_by_zero,
  input  logic        div_overflow
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        op_signed_q, op_signed_d;
  logic        op_sel_r_q, op_sel_r_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        cache_valid_q, cache_valid_d;
  logic [31:0] cache_a_q, cache_a_d;
  logic [31:0] cache_b_q, cache_b_d;
  logic        cache_signed_q, cache_signed_d;
  logic [31:0] cache_q_q, cache_q_d;
  logic [31:0] cache_r_q, cache_r_d;

  logic cache_hit;
  logic cache_wr;
  logic busy;

  assign cache_hit = cache_valid_q && (req_a == cache_a_q) && (req_b == cache_b_q)
                     && ((!req_op[0]) == cache_signed_q);

  always_comb begin
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_signed_d    = op_signed_q;
    op_sel_r_d     = op_sel_r_q;
    resp_data_d    = resp_data_q;
    cache_wr       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          op_a_d      = req_a;
          op_b_d      = req_b;
          op_signed_d = !req_op[0];
          op_sel_r_d  = req_op[1];
          if (cache_hit) begin
            resp_data_d = req_op[1] ? cache_r_q : cache_q_q;
            state_d     = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      // The launch already went out this cycle, so a flush here must still drain it.
      S_ISSUE: state_d = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (div_ready) begin
          cache_wr = 1'b1;
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            resp_data_d = op_sel_r_q ? div_r : div_q;
            state_d     = S_RESP;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (div_ready) begin
          cache_wr = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_RESP: begin
        if (flush || resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cache_valid_d  = cache_valid_q;
    cache_a_d      = cache_a_q;
    cache_b_d      = cache_b_q;
    cache_signed_d = cache_signed_q;
    cache_q_d      = cache_q_q;
    cache_r_d      = cache_r_q;
    if (cache_wr) begin
      cache_valid_d  = 1'b1;
      cache_a_d      = op_a_q;
      cache_b_d      = op_b_q;
      cache_signed_d = op_signed_q;
      cache_q_d      = div_q;
      cache_r_d      = div_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_signed_q    <= 1'b0;
      op_sel_r_q     <= 1'b0;
      resp_data_q    <= '0;
      cache_valid_q  <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_signed_q <= 1'b0;
      cache_q_q      <= '0;
      cache_r_q      <= '0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_signed_q    <= op_signed_d;
      op_sel_r_q     <= op_sel_r_d;
      resp_data_q    <= resp_data_d;
      cache_valid_q  <= cache_valid_d;
      cache_a_q      <= cache_a_d;
      cache_b_q      <= cache_b_d;
      cache_signed_q <= cache_signed_d;
      cache_q_q      <= cache_q_d;
      cache_r_q      <= cache_r_d;
    end
  end

  assign busy          = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_data     = resp_data_q;
  assign div_en        = (state_q == S_ISSUE);
  assign div_a         = op_a_q;
  assign div_b         = op_b_q;
  assign div_is_signed = op_signed_q;

  // Divider special cases are passed through untouched; these confirm what gets captured.
  a_en_single: assert property (@(posedge clk) disable iff (rst) div_en |=> !div_en);
  a_busy_ready: assert property (@(posedge clk) disable iff (rst) busy |-> !req_ready);
  a_dbz_result: assert property (@(posedge clk) disable iff (rst)
    (cache_wr && div_div_by_zero) |-> (div_q == 32'hFFFF_FFFF && div_r == op_a_q));
  a_ovf_result: assert property (@(posedge clk) disable iff (rst)
    (cache_wr && div_overflow) |-> (div_q == 32'h8000_0000 && div_r == 32'h0));

endmodule
